hit_resolver: RTL and testbench

- Game-logic stage directly downstream of the two char_state_handler instances (char 0 on the left, char 1 on the right).
- Each game frame it compares both characters' FSM states, x positions and block flags, and detects attacks that land.
- It issues stun frame counts, which feed back as each handler's load_frame.
- It tracks health and runs the round sequence (ready countdown, fight, over), which drives the handlers' enable.

---
 rtl/fight_pkg.sv | 51 +++++
 rtl/attack_reach_check.sv | 30 +++
 rtl/hit_resolver.sv | 214 +++++++++++++++++++++
 tb/tb_hit_resolver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// fight_pkg: shared encodings for the fighting-game logic.
//   - 4-bit character FSM states (shared with char_state_handler)
//   - round sequencing states
//   - winner codes
//   - next_armed(): per-attacker arming rule used by hit_resolver
package fight_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_LEFT         = 4'd1,
    ST_RIGHT        = 4'd2,
    ST_ATK_START    = 4'd3,
    ST_ATK_ACTIVE   = 4'd4,
    ST_ATK_RECOVERY = 4'd5,
    ST_DIR_START    = 4'd6,
    ST_DIR_ACTIVE   = 4'd7,
    ST_DIR_RECOVERY = 4'd8,
    ST_STUN         = 4'd9
  } char_state_e;

  typedef enum logic [1:0] {
    R_READY = 2'd0,
    R_FIGHT = 2'd1,
    R_OVER  = 2'd2
  } round_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // An attack arms on its start-up frame and disarms once it lands or once
  // the character is back in a non-attacking state, so one swing = one hit.
  function automatic logic next_armed(input logic armed,
                                      input logic [3:0] st,
                                      input logic hit_landed);
    logic nxt;
    nxt = armed;
    if (st == ST_ATK_START || st == ST_DIR_START) begin
      nxt = 1'b1;
    end else if (st == ST_IDLE || st == ST_LEFT || st == ST_RIGHT ||
                 st == ST_STUN) begin
      nxt = 1'b0;
    end
    if (hit_landed) begin
      nxt = 1'b0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/attack_reach_check.sv
// attack_reach_check: combinational reach test for one attacker.
// Ports:
//   atk_state - attacker's character FSM state
//   gap       - signed horizontal gap between the bodies (<= 0 is overlap)
//   in_reach  - attacker is in an active frame and the defender is in range
module attack_reach_check
  import fight_pkg::*;
#(
  parameter int GAP_W         = 12,
  parameter int ATK_RANGE     = 32,
  parameter int DIR_ATK_RANGE = 48
) (
  input  logic [3:0]              atk_state,
  input  logic signed [GAP_W-1:0] gap,
  output logic                    in_reach
);

  localparam logic signed [GAP_W-1:0] ATK_LIM = GAP_W'(ATK_RANGE);
  localparam logic signed [GAP_W-1:0] DIR_LIM = GAP_W'(DIR_ATK_RANGE);

  always_comb begin
    in_reach = 1'b0;
    if (atk_state == ST_ATK_ACTIVE) begin
      in_reach = (gap < ATK_LIM);
    end else if (atk_state == ST_DIR_ACTIVE) begin
      in_reach = (gap < DIR_LIM);
    end
  end

endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: per-frame hit detection, stun issue, health and round flow
// for two characters (char 0 on the left, char 1 on the right).
// Ports:
//   CLOCK, RESET           - clock, synchronous active-high reset
//   frame_tick             - one-cycle pulse per game frame; all updates gated
//   start_btn              - restart request, honoured only in R_OVER
//   p0/p1_state, _x, _block- character FSM state, left edge, block flag
//   p0/p1_load_frame       - stun frames to load into the handler (0 = none)
//   p0/p1_health           - remaining health
//   char_enable            - enable to both handlers (high only in R_FIGHT)
//   hit_event              - bit i pulses one cycle when char i is hit
//   winner                 - 00 none, 01 char 0, 10 char 1, 11 draw
//
// Round FSM:
//   state   | meaning
//   R_READY | countdown running, characters disabled
//   R_FIGHT | characters enabled, hits resolved each frame
//   R_OVER  | round finished, waiting for start_btn
module hit_resolver
  import fight_pkg::*;
#(
  parameter int              X_W              = 10,
  parameter int              CHAR_W           = 64,
  parameter int              ATK_RANGE        = 32,
  parameter int              DIR_ATK_RANGE    = 48,
  parameter logic [4:0]      HITSTUN          = 5'd12,
  parameter logic [4:0]      BLOCKSTUN        = 5'd6,
  parameter int              HP_W             = 2,
  parameter logic [HP_W-1:0] INIT_HEALTH      = 3,
  parameter int              COUNTDOWN_FRAMES = 180
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            frame_tick,
  input  logic            start_btn,
  input  logic [3:0]      p0_state,
  input  logic [3:0]      p1_state,
  input  logic [X_W-1:0]  p0_x,
  input  logic [X_W-1:0]  p1_x,
  input  logic            p0_block,
  input  logic            p1_block,
  output logic [4:0]      p0_load_frame,
  output logic [4:0]      p1_load_frame,
  output logic [HP_W-1:0] p0_health,
  output logic [HP_W-1:0] p1_health,
  output logic            char_enable,
  output logic [1:0]      hit_event,
  output logic [1:0]      winner
);

  localparam int GAP_W = X_W + 2;
  localparam int CNT_W = $clog2(COUNTDOWN_FRAMES + 1);

  round_state_e    round_q, round_d;
  logic [CNT_W-1:0] countdown_q, countdown_d;
  logic [HP_W-1:0] p0_health_q, p0_health_d;
  logic [HP_W-1:0] p1_health_q, p1_health_d;
  logic [4:0]      p0_load_q, p0_load_d;
  logic [4:0]      p1_load_q, p1_load_d;
  logic [1:0]      armed_q, armed_d;
  logic            char_enable_q, char_enable_d;
  logic [1:0]      hit_event_q, hit_event_d;
  logic [1:0]      winner_q, winner_d;

  logic signed [GAP_W-1:0] gap;
  logic                    p0_in_reach;
  logic                    p1_in_reach;
  // hit_on[i]: char i is the defender of a hit landing this tick
  logic [1:0]              hit_on;

  // Two extra bits keep the sum from wrapping and leave room for a sign.
  assign gap = $signed({2'b00, p1_x}) - $signed({2'b00, p0_x})
             - $signed(GAP_W'(CHAR_W));

  attack_reach_check #(
    .GAP_W        (GAP_W),
    .ATK_RANGE    (ATK_RANGE),
    .DIR_ATK_RANGE(DIR_ATK_RANGE)
  ) u_reach_p0 (
    .atk_state(p0_state),
    .gap      (gap),
    .in_reach (p0_in_reach)
  );

  attack_reach_check #(
    .GAP_W        (GAP_W),
    .ATK_RANGE    (ATK_RANGE),
    .DIR_ATK_RANGE(DIR_ATK_RANGE)
  ) u_reach_p1 (
    .atk_state(p1_state),
    .gap      (gap),
    .in_reach (p1_in_reach)
  );

  always_comb begin
    round_d       = round_q;
    countdown_d   = countdown_q;
    p0_health_d   = p0_health_q;
    p1_health_d   = p1_health_q;
    p0_load_d     = p0_load_q;
    p1_load_d     = p1_load_q;
    armed_d       = armed_q;
    char_enable_d = char_enable_q;
    winner_d      = winner_q;
    hit_event_d   = 2'b00;
    hit_on        = 2'b00;

    if (frame_tick) begin
      // A nonzero stun value lives exactly one frame so the handler always
      // sees a fresh 0 -> nonzero edge.
      p0_load_d = 5'd0;
      p1_load_d = 5'd0;

      if (round_q == R_FIGHT) begin
        hit_on[1] = armed_q[0] & p0_in_reach;
        hit_on[0] = armed_q[1] & p1_in_reach;
      end
      hit_event_d = hit_on;

      // A defender already in stun still takes damage but gets no reload.
      if (hit_on[1]) begin
        if (p1_state != ST_STUN) begin
          p1_load_d = p1_block ? BLOCKSTUN : HITSTUN;
        end
        if (!p1_block && p1_health_q != '0) begin
          p1_health_d = p1_health_q - 1'b1;
        end
      end
      if (hit_on[0]) begin
        if (p0_state != ST_STUN) begin
          p0_load_d = p0_block ? BLOCKSTUN : HITSTUN;
        end
        if (!p0_block && p0_health_q != '0) begin
          p0_health_d = p0_health_q - 1'b1;
        end
      end

      armed_d[0] = next_armed(armed_q[0], p0_state, hit_on[1]);
      armed_d[1] = next_armed(armed_q[1], p1_state, hit_on[0]);

      case (round_q)
        R_READY: begin
          if (countdown_q == CNT_W'(1)) begin
            round_d       = R_FIGHT;
            char_enable_d = 1'b1;
          end else begin
            countdown_d = countdown_q - 1'b1;
          end
        end
        R_FIGHT: begin
          if (p0_health_d == '0 || p1_health_d == '0) begin
            round_d       = R_OVER;
            char_enable_d = 1'b0;
            if (p0_health_d == '0 && p1_health_d == '0) begin
              winner_d = WIN_DRAW;
            end else if (p1_health_d == '0) begin
              winner_d = WIN_P0;
            end else begin
              winner_d = WIN_P1;
            end
          end
        end
        R_OVER: begin
          if (start_btn) begin
            round_d     = R_READY;
            countdown_d = CNT_W'(COUNTDOWN_FRAMES);
            p0_health_d = INIT_HEALTH;
            p1_health_d = INIT_HEALTH;
            armed_d     = 2'b00;
            winner_d    = WIN_NONE;
          end
        end
        default: begin
          round_d = R_READY;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      round_q       <= R_READY;
      countdown_q   <= CNT_W'(COUNTDOWN_FRAMES);
      p0_health_q   <= INIT_HEALTH;
      p1_health_q   <= INIT_HEALTH;
      p0_load_q     <= 5'd0;
      p1_load_q     <= 5'd0;
      armed_q       <= 2'b00;
      char_enable_q <= 1'b0;
      hit_event_q   <= 2'b00;
      winner_q      <= WIN_NONE;
    end else begin
      round_q       <= round_d;
      countdown_q   <= countdown_d;
      p0_health_q   <= p0_health_d;
      p1_health_q   <= p1_health_d;
      p0_load_q     <= p0_load_d;
      p1_load_q     <= p1_load_d;
      armed_q       <= armed_d;
      char_enable_q <= char_enable_d;
      hit_event_q   <= hit_event_d;
      winner_q      <= winner_d;
    end
  end

  assign p0_load_frame = p0_load_q;
  assign p1_load_frame = p1_load_q;
  assign p0_health     = p0_health_q;
  assign p1_health     = p1_health_q;
  assign char_enable   = char_enable_q;
  assign hit_event     = hit_event_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: scoreboard bench for hit_resolver. The driver steps a
// frame-level reference model on every tick and queues the expected outputs;
// the monitor pops and compares on the cycle after each tick and checks the
// one-cycle hit pulse / one-frame stun hold on the following cycle.
module tb_hit_resolver;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic [3:0] p0_state = 4'd0, p1_state = 4'd0;
  logic [9:0] p0_x = 10'd100, p1_x = 10'd180;
  logic       p0_block = 1'b0, p1_block = 1'b0;
  logic [4:0] p0_load_frame, p1_load_frame;
  logic [1:0] p0_health, p1_health;
  logic       char_enable;
  logic [1:0] hit_event;
  logic [1:0] winner;

  hit_resolver dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .p0_state     (p0_state),
    .p1_state     (p1_state),
    .p0_x         (p0_x),
    .p1_x         (p1_x),
    .p0_block     (p0_block),
    .p1_block     (p1_block),
    .p0_load_frame(p0_load_frame),
    .p1_load_frame(p1_load_frame),
    .p0_health    (p0_health),
    .p1_health    (p1_health),
    .char_enable  (char_enable),
    .hit_event    (hit_event),
    .winner       (winner)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int lf0, lf1, h0, h1, en, hev, win;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   checks = 0;
  int   passes = 0;

  // Reference model: round 0=ready 1=fight 2=over
  int m_round, m_cd, m_h0, m_h1, m_arm0, m_arm1, m_win;
  int m_lf0, m_lf1, m_hev;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".p0_load_frame"}, int'(p0_load_frame), e.lf0);
    chk({tag, ".p1_load_frame"}, int'(p1_load_frame), e.lf1);
    chk({tag, ".p0_health"},     int'(p0_health),     e.h0);
    chk({tag, ".p1_health"},     int'(p1_health),     e.h1);
    chk({tag, ".char_enable"},   int'(char_enable),   e.en);
    chk({tag, ".hit_event"},     int'(hit_event),     e.hev);
    chk({tag, ".winner"},        int'(winner),        e.win);
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.lf0 = m_lf0; e.lf1 = m_lf1; e.h0 = m_h0; e.h1 = m_h1;
    e.en = (m_round == 1) ? 1 : 0; e.hev = m_hev; e.win = m_win;
    return e;
  endfunction

  task automatic model_reset();
    m_round = 0; m_cd = 180; m_h0 = 3; m_h1 = 3; m_arm0 = 0; m_arm1 = 0;
    m_win = 0; m_lf0 = 0; m_lf1 = 0; m_hev = 0;
  endtask

  function automatic bit reaches(input int s, input int gap);
    return (s == 4 && gap < 32) || (s == 7 && gap < 48);
  endfunction

  function automatic int arm_next(input int arm, input int s, input bit hit);
    if (hit) return 0;
    if (s == 3 || s == 6) return 1;
    if (s <= 2 || s == 9) return 0;
    return arm;
  endfunction

  task automatic model_step(input int s0, input int s1, input int x0, input int x1,
                            input bit b0, input bit b1, input bit st);
    int gap;
    bit on1, on0;
    gap = x1 - (x0 + 64);
    on1 = (m_round == 1) && (m_arm0 != 0) && reaches(s0, gap);
    on0 = (m_round == 1) && (m_arm1 != 0) && reaches(s1, gap);
    m_lf0 = 0; m_lf1 = 0; m_hev = 0;
    if (on1) begin
      m_hev += 2;
      if (s1 != 9) m_lf1 = b1 ? 6 : 12;
      if (!b1 && m_h1 > 0) m_h1--;
    end
    if (on0) begin
      m_hev += 1;
      if (s0 != 9) m_lf0 = b0 ? 6 : 12;
      if (!b0 && m_h0 > 0) m_h0--;
    end
    m_arm0 = arm_next(m_arm0, s0, on1);
    m_arm1 = arm_next(m_arm1, s1, on0);
    case (m_round)
      0: if (m_cd == 1) m_round = 1; else m_cd--;
      1: if (m_h0 == 0 || m_h1 == 0) begin
           m_round = 2;
           m_win = (m_h0 == 0 && m_h1 == 0) ? 3 : (m_h1 == 0 ? 1 : 2);
         end
      default: if (st) begin
           m_round = 0; m_cd = 180; m_h0 = 3; m_h1 = 3;
           m_arm0 = 0; m_arm1 = 0; m_win = 0;
         end
    endcase
  endtask

  // Ends at the negedge where this tick's registered results are visible.
  task automatic do_tick(input int s0, input int s1, input int x0, input int x1,
                         input bit b0, input bit b1, input bit st);
    @(negedge CLOCK);
    p0_state = 4'(s0); p1_state = 4'(s1);
    p0_x = 10'(x0); p1_x = 10'(x1);
    p0_block = b0; p1_block = b1; start_btn = st;
    frame_tick = 1'b1;
    model_step(s0, s1, x0, x1, b0, b1, st);
    exp_q.push_back(model_outputs());
    @(negedge CLOCK);
    frame_tick = 1'b0;
    start_btn = 1'b0;
  endtask

  task automatic idle_ticks(input int n, input int x0, input int x1);
    for (int i = 0; i < n; i++) do_tick(0, 0, x0, x1, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge CLOCK);
    RESET = 1'b1; frame_tick = 1'b0; start_btn = 1'b0;
    @(negedge CLOCK);
    model_reset();
    e = model_outputs();
    check_all(tag, e);
    RESET = 1'b0;
  endtask

  // Monitor
  logic tick_q = 1'b0, tick_qq = 1'b0;
  always @(posedge CLOCK) begin
    tick_q  <= frame_tick;
    tick_qq <= tick_q;
  end

  always @(negedge CLOCK) begin
    if (tick_q) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 0, 1);
      end else begin
        last_e = exp_q.pop_front();
        check_all("tick", last_e);
      end
    end else if (tick_qq && !RESET) begin
      chk("hold.p0_load_frame", int'(p0_load_frame), last_e.lf0);
      chk("hold.p1_load_frame", int'(p1_load_frame), last_e.lf1);
      chk("hold.hit_event", int'(hit_event), 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, x0, x1;
    do_reset("reset");

    // Countdown: enable must still be low after 179 ticks, high after 180.
    idle_ticks(179, 100, 180);
    chk("tp_enable_before_180", int'(char_enable), 0);
    idle_ticks(1, 100, 180);
    chk("tp_enable_after_180", int'(char_enable), 1);

    // Gap 16 neutral hit on char 1
    do_tick(3, 0, 100, 180, 0, 0, 0);
    do_tick(4, 0, 100, 180, 0, 0, 0);
    chk("tp_hit_load", int'(p1_load_frame), 12);
    chk("tp_hit_event", int'(hit_event), 2);
    do_tick(4, 0, 100, 180, 0, 0, 0);
    chk("tp_hit_once_health", int'(p1_health), 2);
    chk("tp_load_cleared", int'(p1_load_frame), 0);
    do_tick(5, 0, 100, 180, 0, 0, 0);
    do_tick(0, 0, 100, 180, 0, 0, 0);

    // Same, blocked
    do_tick(3, 0, 100, 180, 0, 1, 0);
    do_tick(4, 0, 100, 180, 0, 1, 0);
    chk("tp_block_load", int'(p1_load_frame), 6);
    chk("tp_block_health", int'(p1_health), 2);
    do_tick(5, 0, 100, 180, 0, 1, 0);
    do_tick(0, 0, 100, 180, 0, 0, 0);

    // Gap 40: neutral misses, directional lands
    do_tick(3, 0, 100, 204, 0, 0, 0);
    do_tick(4, 0, 100, 204, 0, 0, 0);
    chk("tp_gap40_neutral_miss", int'(p1_load_frame), 0);
    do_tick(5, 0, 100, 204, 0, 0, 0);
    do_tick(6, 0, 100, 204, 0, 0, 0);
    do_tick(7, 0, 100, 204, 0, 0, 0);
    chk("tp_gap40_dir_hit", int'(p1_load_frame), 12);
    do_tick(8, 0, 100, 204, 0, 0, 0);
    do_tick(0, 0, 100, 204, 0, 0, 0);

    // Char 1 brings char 0 down to 1
    for (int k = 0; k < 2; k++) begin
      do_tick(0, 3, 100, 180, 0, 0, 0);
      do_tick(0, 4, 100, 180, 0, 0, 0);
      do_tick(0, 5, 100, 180, 0, 0, 0);
      do_tick(0, 0, 100, 180, 0, 0, 0);
    end
    chk("tp_p0_health_1", int'(p0_health), 1);

    // Trade at gap 0 -> draw
    do_tick(3, 3, 100, 164, 0, 0, 0);
    do_tick(4, 4, 100, 164, 0, 0, 0);
    chk("tp_trade_winner", int'(winner), 3);
    chk("tp_trade_enable", int'(char_enable), 0);
    chk("tp_trade_hit_event", int'(hit_event), 3);
    idle_ticks(3, 100, 164);

    // Restart from R_OVER
    do_tick(0, 0, 100, 180, 0, 0, 1);
    chk("tp_restart_winner", int'(winner), 0);
    chk("tp_restart_health", int'(p0_health) + 4 * int'(p1_health), 15);

    // Into the fight again, land a hit, then reset mid-round
    idle_ticks(180, 100, 180);
    do_tick(3, 0, 100, 180, 0, 0, 0);
    do_tick(4, 0, 100, 180, 0, 0, 0);
    do_reset("midround_reset");

    // Randomized frames
    for (int i = 0; i < 1300; i++) begin
      s0 = $urandom_range(0, 9);
      s1 = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) begin
        x0 = $urandom_range(0, 1023);
        x1 = $urandom_range(0, 1023);
      end else begin
        x0 = $urandom_range(0, 300);
        x1 = x0 + $urandom_range(0, 150);
      end
      do_tick(s0, s1, x0, x1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge CLOCK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
